// File: rtl/ysyx_25030081_mc_ctrl_if.sv
// Shared memory port between the multi-cycle sequencer (master) and the memory (slave).
// The request holds until ready. Responses are one-cycle pulses, and err is qualified by resp_valid.
interface ysyx_25030081_mc_ctrl_if;
  logic mem_req_valid;
  logic mem_req_ready;
  logic mem_req_we;
  logic mem_req_fetch;
  logic mem_resp_valid;
  logic mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_fetch,
    input  mem_req_ready, mem_resp_valid, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_fetch,
    output mem_req_ready, mem_resp_valid, mem_resp_err
  );
endinterface

// File: rtl/ysyx_25030081_mc_ctrl.sv
// NPC multi-cycle sequencer: IF/EX/MEM/WB over one shared memory port; 4 cycles ALU, 6 load/store at zero wait; requests hold until ready.
// Halts on ebreak/bus error/illegal/timeout. YSYX_25030081_PERF_EN adds cycle_cnt/instret_cnt outputs.
module ysyx_25030081_mc_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ysyx_25030081_mc_ctrl_if.master bus,
  input  logic                 dec_reg_wen,
  input  logic                 dec_mem_ren,
  input  logic                 dec_mem_wen,
  input  logic                 dec_ebreak,
  input  logic                 dec_illegal,
  output logic                 ir_wen,
  output logic                 lsu_wen,
  output logic                 rf_wen,
  output logic                 pc_wen,
  output logic                 halt,
  output logic [1:0]           halt_code,
  output logic [2:0]           state
`ifdef YSYX_25030081_PERF_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  localparam logic [1:0]  CODE_EBREAK  = 2'd0;
  localparam logic [1:0]  CODE_BUSERR  = 2'd1;
  localparam logic [1:0]  CODE_ILLEGAL = 2'd2;
  localparam logic [1:0]  CODE_TIMEOUT = 2'd3;
  localparam logic [31:0] TO_LAST      = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_code;
  logic [1:0]  w_code;
  logic        r_reg_wen;
  logic        r_is_load;
  logic        r_is_store;
  logic [31:0] r_to_cnt;
  logic        w_to_hit;
  logic        w_timed;

  // A request/wait state counts its own dwell; the cycle reaching the limit halts unless served.
  assign w_timed  = (r_state == S_IF_REQ) || (r_state == S_IF_WAIT) ||
                    (r_state == S_MEM_REQ) || (r_state == S_MEM_WAIT);
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && w_timed && (r_to_cnt == TO_LAST);

  always_comb begin
    w_next            = r_state;
    w_code            = r_code;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_fetch = 1'b0;
    ir_wen            = 1'b0;
    lsu_wen           = 1'b0;
    rf_wen            = 1'b0;
    pc_wen            = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_IF_REQ;
      S_IF_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_fetch = 1'b1;
        if (bus.mem_req_ready) begin
          w_next = S_IF_WAIT;
        end else if (w_to_hit) begin
          w_next = S_HALT;
          w_code = CODE_TIMEOUT;
        end
      end
      S_IF_WAIT: begin
        if (bus.mem_resp_valid) begin
          if (bus.mem_resp_err) begin
            w_next = S_HALT;
            w_code = CODE_BUSERR;
          end else begin
            ir_wen = 1'b1;
            w_next = S_EX;
          end
        end else if (w_to_hit) begin
          w_next = S_HALT;
          w_code = CODE_TIMEOUT;
        end
      end
      S_EX: begin
        if (dec_illegal) begin
          w_next = S_HALT;
          w_code = CODE_ILLEGAL;
        end else if (dec_ebreak) begin
          w_next = S_HALT;
          w_code = CODE_EBREAK;
        end else if (dec_mem_ren || dec_mem_wen) begin
          w_next = S_MEM_REQ;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = r_is_store;
        if (bus.mem_req_ready) begin
          w_next = S_MEM_WAIT;
        end else if (w_to_hit) begin
          w_next = S_HALT;
          w_code = CODE_TIMEOUT;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_resp_valid) begin
          if (bus.mem_resp_err) begin
            w_next = S_HALT;
            w_code = CODE_BUSERR;
          end else begin
            lsu_wen = r_is_load;
            w_next  = S_WB;
          end
        end else if (w_to_hit) begin
          w_next = S_HALT;
          w_code = CODE_TIMEOUT;
        end
      end
      S_WB: begin
        rf_wen = r_reg_wen;
        pc_wen = 1'b1;
        w_next = S_IF_REQ;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_code     <= 2'd0;
      r_reg_wen  <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      if (r_state == S_EX) begin
        r_reg_wen  <= dec_reg_wen;
        r_is_load  <= dec_mem_ren;
        r_is_store <= dec_mem_wen;
      end
      // No state self-loops across visits, so any transition is an entry.
      if (w_next != r_state) begin
        r_to_cnt <= '0;
      end else if (w_timed) begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end
    end
  end

  assign halt      = (r_state == S_HALT);
  assign halt_code = r_code;
  assign state     = r_state;

`ifdef YSYX_25030081_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
      if (r_state == S_WB) begin
        r_instret_cnt <= r_instret_cnt + 1'b1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
